// File: rtl/fwd_scoreboard_pkg.sv
// rtl/fwd_scoreboard_pkg.sv - shared types and constants for the forwarding scoreboard
// Entry layout gains hi_we/lo_we when HILO_FWD_EN is defined.
package fwd_scoreboard_pkg;

   localparam int RAW    = 5;
   localparam int SB_EX  = 0;
   localparam int SB_MEM = 1;
   localparam int SB_WB  = 2;

   typedef struct packed {
      logic           valid;
      logic           we;
      logic [RAW-1:0] waddr;
      logic           is_load;
`ifdef HILO_FWD_EN
      logic           hi_we;
      logic           lo_we;
`endif
   } sb_entry_t;

endpackage

// File: rtl/fwd_port_sel.sv
// rtl/fwd_port_sel.sv - youngest-first priority matcher over the scoreboard stages
// Returns whether any stage matched, which one won, and whether its data is valid yet.
module fwd_port_sel #(
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 1,
   parameter int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic [DEPTH-1:0] match,
   input  logic [DEPTH-1:0] is_load,
   output logic             hit,
   output logic [IW-1:0]    sel,
   output logic             ready
);

   // Scan oldest to youngest so the lowest matching index is the last to assign.
   always_comb begin
      hit   = 1'b0;
      sel   = '0;
      ready = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (match[k]) begin
            hit   = 1'b1;
            sel   = IW'(k);
            ready = !is_load[k] || (k >= LOAD_READY);
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - forwarding scoreboard and load-use hazard unit beside ID
// Optional HI/LO forwarding is enabled with the HILO_FWD_EN macro.
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int DEPTH      = 3,
   parameter int NRP        = 2,
   parameter int DW         = 32,
   parameter int LOAD_READY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold,
   input  logic                 id_valid,
   input  logic                 id_we,
   input  logic [RAW-1:0]       id_waddr,
   input  logic                 id_is_load,
   input  logic [NRP*RAW-1:0]   id_raddr,
   input  logic [NRP*DW-1:0]    rf_rdata,
   input  logic [DEPTH*DW-1:0]  stage_wdata,
`ifdef HILO_FWD_EN
   input  logic [DW-1:0]        hi_in,
   input  logic [DW-1:0]        lo_in,
   input  logic                 id_hi_we,
   input  logic                 id_lo_we,
   input  logic [DEPTH*DW-1:0]  stage_hi,
   input  logic [DEPTH*DW-1:0]  stage_lo,
   output logic [DW-1:0]        hi_fwd,
   output logic [DW-1:0]        lo_fwd,
`endif
   output logic [NRP*DW-1:0]    fwd_rdata,
   output logic [NRP-1:0]       fwd_hit,
   output logic                 stallreq
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   sb_entry_t         stage_q [DEPTH];
   sb_entry_t         new_entry;
   logic [DW-1:0]     stage_data [DEPTH];
   logic [NRP-1:0]    port_stall;

   always_comb begin
      new_entry         = '0;
      new_entry.valid   = 1'b1;
      new_entry.we      = id_we;
      new_entry.waddr   = id_waddr;
      new_entry.is_load = id_is_load;
`ifdef HILO_FWD_EN
      new_entry.hi_we   = id_hi_we;
      new_entry.lo_we   = id_lo_we;
`endif
   end

   // A stalled ID instruction stays put, so EX receives a bubble instead.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else if (!hold) begin
         for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
         stage_q[SB_EX] <= (id_valid && !stallreq) ? new_entry : '0;
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_data
      assign stage_data[k] = stage_wdata[DW*k +: DW];
   end

   for (genvar r = 0; r < NRP; r++) begin : g_port
      logic [RAW-1:0]   raddr;
      logic [DEPTH-1:0] match;
      logic [DEPTH-1:0] load;
      logic             hit;
      logic             ready;
      logic [IW-1:0]    sel;

      assign raddr = id_raddr[RAW*r +: RAW];

      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         assign match[k] = stage_q[k].valid && stage_q[k].we &&
                           (stage_q[k].waddr == raddr) && (raddr != '0);
         assign load[k]  = stage_q[k].is_load;
      end

      fwd_port_sel #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .IW(IW)) u_sel (
         .match   (match),
         .is_load (load),
         .hit     (hit),
         .sel     (sel),
         .ready   (ready)
      );

      assign fwd_rdata[DW*r +: DW] = (hit && ready) ? stage_data[sel] : rf_rdata[DW*r +: DW];
      assign fwd_hit[r]            = hit && ready;
      assign port_stall[r]         = hit && !ready;
   end

   assign stallreq = id_valid && (|port_stall);

`ifdef HILO_FWD_EN
   // HI/LO producers are never loads, so they are always ready.
   logic [DEPTH-1:0] hi_match, lo_match;
   logic [DW-1:0]    hi_data [DEPTH];
   logic [DW-1:0]    lo_data [DEPTH];
   logic             hi_hit, hi_ready, lo_hit, lo_ready;
   logic [IW-1:0]    hi_sel, lo_sel;

   for (genvar k = 0; k < DEPTH; k++) begin : g_hilo
      assign hi_match[k] = stage_q[k].valid && stage_q[k].hi_we;
      assign lo_match[k] = stage_q[k].valid && stage_q[k].lo_we;
      assign hi_data[k]  = stage_hi[DW*k +: DW];
      assign lo_data[k]  = stage_lo[DW*k +: DW];
   end

   fwd_port_sel #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .IW(IW)) u_hi_sel (
      .match   (hi_match),
      .is_load ('0),
      .hit     (hi_hit),
      .sel     (hi_sel),
      .ready   (hi_ready)
   );

   fwd_port_sel #(.DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .IW(IW)) u_lo_sel (
      .match   (lo_match),
      .is_load ('0),
      .hit     (lo_hit),
      .sel     (lo_sel),
      .ready   (lo_ready)
   );

   assign hi_fwd = (hi_hit && hi_ready) ? hi_data[hi_sel] : hi_in;
   assign lo_fwd = (lo_hit && lo_ready) ? lo_data[lo_sel] : lo_in;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - directed self-checking bench for fwd_scoreboard
// Default build (HILO_FWD_EN undefined), DEPTH=3, NRP=2, DW=32, LOAD_READY=1.
module tb_fwd_scoreboard;
   import fwd_scoreboard_pkg::*;

   localparam int DEPTH = 3;
   localparam int NRP   = 2;
   localparam int DW    = 32;

   logic                clk = 1'b0;
   logic                rst, hold, id_valid, id_we, id_is_load;
   logic [4:0]          id_waddr;
   logic [NRP*5-1:0]    id_raddr;
   logic [NRP*DW-1:0]   rf_rdata;
   logic [DEPTH*DW-1:0] stage_wdata;
   logic [NRP*DW-1:0]   fwd_rdata;
   logic [NRP-1:0]      fwd_hit;
   logic                stallreq;

   int n_checks = 0;
   int n_fail   = 0;

   fwd_scoreboard #(.DEPTH(DEPTH), .NRP(NRP), .DW(DW), .LOAD_READY(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .hold        (hold),
      .id_valid    (id_valid),
      .id_we       (id_we),
      .id_waddr    (id_waddr),
      .id_is_load  (id_is_load),
      .id_raddr    (id_raddr),
      .rf_rdata    (rf_rdata),
      .stage_wdata (stage_wdata),
      .fwd_rdata   (fwd_rdata),
      .fwd_hit     (fwd_hit),
      .stallreq    (stallreq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hold = 0; id_valid = 0; id_we = 0; id_waddr = 0; id_is_load = 0; id_raddr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   // Put one instruction into EX on the next edge; reads $0 so it never stalls.
   task automatic issue(input logic we, input logic [4:0] waddr, input logic load);
      id_valid = 1; id_we = we; id_waddr = waddr; id_is_load = load; id_raddr = 0;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      rf_rdata = {32'hCAFE_0001, 32'hCAFE_0000};
      stage_wdata = {32'h3, 32'h2, 32'h1};
      do_reset();
      id_valid = 1; id_raddr = {5'd2, 5'd1};
      #1;
      n_checks++;
      if (fwd_hit !== 2'b00) begin n_fail++; $display("FAIL reset_hit got %b want 00", fwd_hit); end
      n_checks++;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stallreq); end
      n_checks++;
      if (fwd_rdata !== {32'hCAFE_0001, 32'hCAFE_0000}) begin
         n_fail++; $display("FAIL reset_rdata got %h want cafe0001cafe0000", fwd_rdata);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      issue(1, 5'd3, 0);
      stage_wdata = {32'h99, 32'h77, 32'h11};
      rf_rdata = {32'h44, 32'h33};
      id_valid = 1; id_raddr = {5'd4, 5'd3};
      #1;
      n_checks++;
      if (fwd_rdata[31:0] !== 32'h11 || fwd_hit[0] !== 1'b1) begin
         n_fail++; $display("FAIL b2b_port0 got %h/%b want 00000011/1", fwd_rdata[31:0], fwd_hit[0]);
      end
      n_checks++;
      if (fwd_rdata[63:32] !== 32'h44 || fwd_hit[1] !== 1'b0) begin
         n_fail++; $display("FAIL b2b_port1 got %h/%b want 00000044/0", fwd_rdata[63:32], fwd_hit[1]);
      end
      n_checks++;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got %b want 0", stallreq); end
   endtask

   task automatic test_load_use();
      do_reset();
      issue(1, 5'd5, 1);
      stage_wdata = {32'h0, 32'hA5A5, 32'hDEAD};
      rf_rdata = {32'h66, 32'h55};
      id_valid = 1; id_we = 1; id_waddr = 5'd6; id_raddr = {5'd0, 5'd5};
      #1;
      n_checks++;
      if (stallreq !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stallreq); end
      n_checks++;
      if (fwd_hit[0] !== 1'b0) begin n_fail++; $display("FAIL lu_hit_early got %b want 0", fwd_hit[0]); end
      step();
      n_checks++;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL lu_stall_next got %b want 0", stallreq); end
      n_checks++;
      if (fwd_rdata[31:0] !== 32'hA5A5 || fwd_hit[0] !== 1'b1) begin
         n_fail++; $display("FAIL lu_fwd got %h/%b want 0000a5a5/1", fwd_rdata[31:0], fwd_hit[0]);
      end
      // The dependent instruction now enters EX; $6 must be visible there.
      step();
      idle_inputs();
      id_valid = 1; id_raddr = {5'd6, 5'd0};
      stage_wdata = {32'h0, 32'h0, 32'h600D};
      #1;
      n_checks++;
      if (fwd_rdata[63:32] !== 32'h600D || fwd_hit[1] !== 1'b1) begin
         n_fail++; $display("FAIL lu_dep_enters got %h/%b want 0000600d/1", fwd_rdata[63:32], fwd_hit[1]);
      end
   endtask

   task automatic test_priority();
      do_reset();
      issue(1, 5'd7, 0);
      step();
      issue(1, 5'd7, 0);
      stage_wdata = {32'h2, 32'h99, 32'h1};
      id_valid = 1; id_raddr = {5'd0, 5'd7};
      #1;
      n_checks++;
      if (fwd_rdata[31:0] !== 32'h1 || fwd_hit[0] !== 1'b1) begin
         n_fail++; $display("FAIL prio_youngest got %h/%b want 00000001/1", fwd_rdata[31:0], fwd_hit[0]);
      end
      do_reset();
      issue(1, 5'd7, 0);
      step();
      issue(1, 5'd7, 1);
      id_valid = 1; id_raddr = {5'd0, 5'd7};
      #1;
      n_checks++;
      if (stallreq !== 1'b1) begin n_fail++; $display("FAIL prio_load_stall got %b want 1", stallreq); end
      id_valid = 0;
      #1;
      n_checks++;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL prio_gated got %b want 0", stallreq); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      issue(1, 5'd0, 1);
      rf_rdata = {32'h0, 32'h1234};
      stage_wdata = {32'h0, 32'h0, 32'hBAD};
      id_valid = 1; id_raddr = {5'd0, 5'd0};
      #1;
      n_checks++;
      if (fwd_hit !== 2'b00 || fwd_rdata[31:0] !== 32'h1234) begin
         n_fail++; $display("FAIL zero_reg got %h/%b want 00001234/00", fwd_rdata[31:0], fwd_hit);
      end
      n_checks++;
      if (stallreq !== 1'b0) begin n_fail++; $display("FAIL zero_stall got %b want 0", stallreq); end
   endtask

   task automatic test_hold();
      do_reset();
      issue(1, 5'd5, 1);
      stage_wdata = {32'h0, 32'hF00D, 32'h0};
      id_valid = 1; id_we = 1; id_waddr = 5'd8; id_raddr = {5'd0, 5'd5};
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (stallreq !== 1'b1 || fwd_hit[0] !== 1'b0) begin
            n_fail++; $display("FAIL hold_cycle%0d got %b/%b want 1/0", i, stallreq, fwd_hit[0]);
         end
      end
      hold = 0;
      step();
      n_checks++;
      if (stallreq !== 1'b0 || fwd_rdata[31:0] !== 32'hF00D || fwd_hit[0] !== 1'b1) begin
         n_fail++; $display("FAIL hold_release got %b/%h/%b want 0/0000f00d/1", stallreq, fwd_rdata[31:0], fwd_hit[0]);
      end
   endtask

   task automatic test_wb_exit();
      do_reset();
      issue(1, 5'd9, 0);
      step();
      step();
      stage_wdata = {32'h9009, 32'h0, 32'h0};
      rf_rdata = {32'h0, 32'h0909};
      id_valid = 1; id_raddr = {5'd0, 5'd9};
      #1;
      n_checks++;
      if (fwd_rdata[31:0] !== 32'h9009 || fwd_hit[0] !== 1'b1) begin
         n_fail++; $display("FAIL wb_fwd got %h/%b want 00009009/1", fwd_rdata[31:0], fwd_hit[0]);
      end
      id_valid = 0;
      step();
      id_valid = 1;
      #1;
      n_checks++;
      if (fwd_rdata[31:0] !== 32'h0909 || fwd_hit[0] !== 1'b0) begin
         n_fail++; $display("FAIL wb_exit got %h/%b want 00000909/0", fwd_rdata[31:0], fwd_hit[0]);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      issue(1, 5'd5, 1);
      id_valid = 1; id_raddr = {5'd0, 5'd5};
      #1;
      n_checks++;
      if (stallreq !== 1'b1) begin n_fail++; $display("FAIL rms_pre got %b want 1", stallreq); end
      rst = 1;
      step();
      rst = 0;
      #1;
      n_checks++;
      if (stallreq !== 1'b0 || fwd_hit !== 2'b00) begin
         n_fail++; $display("FAIL rms_post got %b/%b want 0/00", stallreq, fwd_hit);
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      rf_rdata = '0;
      stage_wdata = '0;
      test_reset();
      test_back_to_back();
      test_load_use();
      test_priority();
      test_zero_reg();
      test_hold();
      test_wb_exit();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
